// File: rtl/sync_edge_filter_pkg.sv
// Shared types and sizing helpers for the debounce filter (sync_edge_filter).
package sync_edge_filter_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    QUAL_RISE   = 2'd1,
    HIGH_STABLE = 2'd2,
    QUAL_FALL   = 2'd3
  } filt_state_e;

  // Qualification counter must hold values up to STABLE_CYCLES.
  function automatic int cnt_width(input int stable_cycles);
    if (stable_cycles < 1) begin
      return 1;
    end else begin
      return $clog2(stable_cycles + 1);
    end
  endfunction

endpackage

// File: rtl/sync_sat_counter.sv
// Generic saturating up-counter with synchronous clear; clear beats increment.
module sync_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {W{1'b0}};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sync_edge_filter.sv
// Debounce filter on a synchronised level: filtered level, edge pulses, glitch count.
// Optional macro SYNC_EDGE_FILTER_INPUT_SYNC_EN adds a two-flop input synchroniser.
module sync_edge_filter
  import sync_edge_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk_b,
  input  logic                rst_b,
  input  logic                sig_b,
  input  logic                glitch_clr,
  output logic                sig_f,
  output logic                rise_p,
  output logic                fall_p,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);

  logic        sig_s;
  logic        glitch_ev_s;
  filt_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic        sig_f_q;
  logic        rise_q;
  logic        fall_q;

`ifdef SYNC_EDGE_FILTER_INPUT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser so an asynchronous source can be connected directly.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_b;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q;
`else
  assign sig_s = sig_b;
`endif

  // Qualification FSM; filtered level and edge pulses are flops updated at commit.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      state_q <= LOW_STABLE;
      cnt_q   <= CNT_ZERO;
      sig_f_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW_STABLE: begin
          if (sig_s) begin
            if (SINGLE_CYCLE) begin
              state_q <= HIGH_STABLE;
              cnt_q   <= CNT_ZERO;
              sig_f_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= QUAL_RISE;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            cnt_q <= CNT_ZERO;
          end
        end
        QUAL_RISE: begin
          if (!sig_s) begin
            state_q <= LOW_STABLE;
            cnt_q   <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH_STABLE;
            cnt_q   <= CNT_ZERO;
            sig_f_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HIGH_STABLE: begin
          if (!sig_s) begin
            if (SINGLE_CYCLE) begin
              state_q <= LOW_STABLE;
              cnt_q   <= CNT_ZERO;
              sig_f_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= QUAL_FALL;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            cnt_q <= CNT_ZERO;
          end
        end
        QUAL_FALL: begin
          if (sig_s) begin
            state_q <= HIGH_STABLE;
            cnt_q   <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW_STABLE;
            cnt_q   <= CNT_ZERO;
            sig_f_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= LOW_STABLE;
          cnt_q   <= CNT_ZERO;
          sig_f_q <= 1'b0;
        end
      endcase
    end
  end

  // A glitch is a qualification abandoned before reaching the window.
  always_comb begin
    glitch_ev_s = 1'b0;
    case (state_q)
      QUAL_RISE: begin
        if (!sig_s) begin
          glitch_ev_s = 1'b1;
        end else begin
          glitch_ev_s = 1'b0;
        end
      end
      QUAL_FALL: begin
        if (sig_s) begin
          glitch_ev_s = 1'b1;
        end else begin
          glitch_ev_s = 1'b0;
        end
      end
      default: glitch_ev_s = 1'b0;
    endcase
  end

  sync_sat_counter #(
    .W(GLITCH_W)
  ) u_glitch_cnt (
    .clk_i (clk_b),
    .rst_i (rst_b),
    .clr_i (glitch_clr),
    .inc_i (glitch_ev_s),
    .cnt_o (glitch_cnt)
  );

  assign sig_f  = sig_f_q;
  assign rise_p = rise_q;
  assign fall_p = fall_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed self-checking bench for sync_edge_filter (default build, no input synchroniser).
module tb_sync_edge_filter;

  logic clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  logic       rst_b;
  logic       sig_b, glitch_clr;
  logic       sig_f, rise_p, fall_p;
  logic [7:0] glitch_cnt;

  logic       sig_b1, clr1, sig_f1, rise_p1, fall_p1;
  logic [7:0] glitch_cnt1;

  logic       sig_b2, clr2, sig_f2, rise_p2, fall_p2;
  logic [1:0] glitch_cnt2;

  int checks = 0;
  int errors = 0;

  sync_edge_filter #(.STABLE_CYCLES(4), .GLITCH_W(8)) u_dut (
    .clk_b(clk_b), .rst_b(rst_b), .sig_b(sig_b), .glitch_clr(glitch_clr),
    .sig_f(sig_f), .rise_p(rise_p), .fall_p(fall_p), .glitch_cnt(glitch_cnt)
  );

  sync_edge_filter #(.STABLE_CYCLES(1), .GLITCH_W(8)) u_s1 (
    .clk_b(clk_b), .rst_b(rst_b), .sig_b(sig_b1), .glitch_clr(clr1),
    .sig_f(sig_f1), .rise_p(rise_p1), .fall_p(fall_p1), .glitch_cnt(glitch_cnt1)
  );

  sync_edge_filter #(.STABLE_CYCLES(4), .GLITCH_W(2)) u_g2 (
    .clk_b(clk_b), .rst_b(rst_b), .sig_b(sig_b2), .glitch_clr(clr2),
    .sig_f(sig_f2), .rise_p(rise_p2), .fall_p(fall_p2), .glitch_cnt(glitch_cnt2)
  );

  typedef struct {
    logic       sig;
    logic       clr;
    logic       f;
    logic       r;
    logic       fl;
    logic [7:0] g;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    #1;
  endtask

  task automatic add(input logic s, input logic c, input logic f, input logic r,
                     input logic fl, input int g);
    vec_t v;
    v.sig = s; v.clr = c; v.f = f; v.r = r; v.fl = fl; v.g = 8'(g);
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b = 1'b1;
    sig_b = 1'b0; glitch_clr = 1'b0;
    sig_b1 = 1'b0; clr1 = 1'b0;
    sig_b2 = 1'b0; clr2 = 1'b0;

    // Reset held with toggling input.
    for (int i = 0; i < 3; i++) begin
      sig_b = ~sig_b;
      step();
      chk("rst_sig_f", sig_f, 1'b0);
      chk("rst_rise", rise_p, 1'b0);
      chk("rst_fall", fall_p, 1'b0);
      chk("rst_gcnt", glitch_cnt, 8'd0);
    end
    rst_b = 1'b0;
    sig_b = 1'b0;
    step();

    // sig, clr, exp sig_f, exp rise, exp fall, exp glitch_cnt
    add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 2); add(1, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 3); add(1, 0, 0, 0, 0, 3); add(1, 0, 0, 0, 0, 3);
    add(1, 0, 1, 1, 0, 3); add(1, 0, 1, 0, 0, 3); add(1, 0, 1, 0, 0, 3);
    add(1, 0, 1, 0, 0, 3); add(1, 0, 1, 0, 0, 3); add(1, 0, 1, 0, 0, 3);
    add(0, 0, 1, 0, 0, 3); add(0, 0, 1, 0, 0, 3); add(0, 0, 1, 0, 0, 3);
    add(1, 0, 1, 0, 0, 4); add(0, 0, 1, 0, 0, 4); add(0, 0, 1, 0, 0, 4);
    add(0, 0, 1, 0, 0, 4); add(0, 0, 0, 0, 1, 4); add(0, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      sig_b      = tbl[i].sig;
      glitch_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_sig_f", i), sig_f, tbl[i].f);
      chk($sformatf("v%0d_rise", i), rise_p, tbl[i].r);
      chk($sformatf("v%0d_fall", i), fall_p, tbl[i].fl);
      chk($sformatf("v%0d_gcnt", i), glitch_cnt, tbl[i].g);
    end
    glitch_clr = 1'b0;
    sig_b = 1'b0;

    // Single-cycle window: one high sample commits immediately.
    sig_b1 = 1'b1;
    step();
    chk("s1_sig_f_hi", sig_f1, 1'b1);
    chk("s1_rise", rise_p1, 1'b1);
    chk("s1_fall_lo", fall_p1, 1'b0);
    sig_b1 = 1'b0;
    step();
    chk("s1_sig_f_lo", sig_f1, 1'b0);
    chk("s1_rise_done", rise_p1, 1'b0);
    chk("s1_fall", fall_p1, 1'b1);
    step();
    chk("s1_fall_done", fall_p1, 1'b0);
    chk("s1_gcnt", glitch_cnt1, 8'd0);

    // Two-bit glitch counter saturation and clear-wins.
    for (int k = 1; k <= 5; k++) begin
      sig_b2 = 1'b1;
      step();
      sig_b2 = 1'b0;
      step();
      chk($sformatf("sat_g%0d", k), glitch_cnt2, (k > 3) ? 2'd3 : 2'(k));
    end
    sig_b2 = 1'b1;
    step();
    sig_b2 = 1'b0;
    clr2 = 1'b1;
    step();
    chk("sat_clr_wins", glitch_cnt2, 2'd0);
    clr2 = 1'b0;
    sig_b2 = 1'b1;
    step();
    sig_b2 = 1'b0;
    step();
    chk("sat_after_clr", glitch_cnt2, 2'd1);
    chk("sat_sig_f", sig_f2, 1'b0);

    // Reset during rise qualification aborts it; qualification restarts from zero.
    sig_b = 1'b1;
    step();
    step();
    #2;
    rst_b = 1'b1;
    #1;
    chk("mid_rst_sig_f", sig_f, 1'b0);
    chk("mid_rst_rise", rise_p, 1'b0);
    step();
    chk("mid_rst_hold_rise", rise_p, 1'b0);
    rst_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("post_rst_e%0d_rise", i), rise_p, 1'b0);
      chk($sformatf("post_rst_e%0d_sig_f", i), sig_f, 1'b0);
    end
    step();
    chk("post_rst_commit_rise", rise_p, 1'b1);
    chk("post_rst_commit_sig_f", sig_f, 1'b1);
    chk("post_rst_gcnt", glitch_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
